ghost_mode_ctrl: RTL and testbench

- Global ghost-mode sequencer, directly upstream of the per-ghost movement blocks (Blinky and siblings).
- Runs the arcade scatter/chase schedule by counting frame_tick pulses and overlays frightened mode when Pac-Man eats an energizer.
- Drives isChase/isScatter to every ghost, plus a one-cycle reverse pulse and frightened/flash flags for ghost AI and sprite colouring.

---
 rtl/ghost_mode_ctrl.sv | 123 ++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_ctrl.sv
// rtl/ghost_mode_ctrl.sv - global scatter/chase schedule with frightened-mode overlay
// Counts frame ticks per phase; an energizer freezes the schedule until fright expires.
module ghost_mode_ctrl #(
  parameter int unsigned SCATTER1      = 420,
  parameter int unsigned CHASE1        = 1200,
  parameter int unsigned SCATTER2      = 420,
  parameter int unsigned CHASE2        = 1200,
  parameter int unsigned SCATTER3      = 300,
  parameter int unsigned CHASE3        = 1200,
  parameter int unsigned SCATTER4      = 300,
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned FLASH_FRAMES  = 120,
  parameter int unsigned CNT_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic       energizer_eaten,
  output logic       isChase,
  output logic       isScatter,
  output logic       isFrightened,
  output logic       fright_flash,
  output logic       reverse,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FRIGHT_LD  = CNT_W'(FRIGHT_FRAMES);
  localparam logic [CNT_W-1:0] FLASH_LIM  = CNT_W'(FLASH_FRAMES);
  localparam logic             FRIGHT_ON  = (FRIGHT_FRAMES != 0);

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0] fright_cnt_q, fright_cnt_d;
  logic             fright_q, fright_d;
  logic             flash_q, flash_d;
  logic             chase_q, chase_d;
  logic             scatter_q, scatter_d;
  logic             reverse_q, reverse_d;
  logic             energize;

  // Last count value of each phase; phase 7 never ends so its entry is unused.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] p);
    case (p)
      3'd0:    return CNT_W'(SCATTER1 - 1);
      3'd1:    return CNT_W'(CHASE1 - 1);
      3'd2:    return CNT_W'(SCATTER2 - 1);
      3'd3:    return CNT_W'(CHASE2 - 1);
      3'd4:    return CNT_W'(SCATTER3 - 1);
      3'd5:    return CNT_W'(CHASE3 - 1);
      3'd6:    return CNT_W'(SCATTER4 - 1);
      default: return '0;
    endcase
  endfunction

  assign energize = energizer_eaten && FRIGHT_ON;

  always_comb begin
    phase_d      = phase_q;
    phase_cnt_d  = phase_cnt_q;
    fright_d     = fright_q;
    fright_cnt_d = fright_cnt_q;
    reverse_d    = 1'b0;
    if (restart) begin
      phase_d      = '0;
      phase_cnt_d  = '0;
      fright_d     = 1'b0;
      fright_cnt_d = '0;
    end else if (energize) begin
      // Takes priority over a coinciding phase end or fright expiry.
      fright_d     = 1'b1;
      fright_cnt_d = FRIGHT_LD;
      reverse_d    = 1'b1;
    end else if (fright_q) begin
      if (frame_tick) begin
        fright_cnt_d = fright_cnt_q - CNT_ONE;
        if (fright_cnt_q == CNT_ONE) fright_d = 1'b0;
      end
    end else if (frame_tick && phase_q != 3'd7) begin
      if (phase_cnt_q == last_cnt(phase_q)) begin
        phase_d     = phase_q + 3'd1;
        phase_cnt_d = '0;
        reverse_d   = 1'b1;
      end else begin
        phase_cnt_d = phase_cnt_q + CNT_ONE;
      end
    end
    flash_d   = fright_d && (fright_cnt_d <= FLASH_LIM);
    chase_d   = !fright_d && phase_d[0];
    scatter_d = !fright_d && !phase_d[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= '0;
      phase_cnt_q  <= '0;
      fright_cnt_q <= '0;
      fright_q     <= 1'b0;
      flash_q      <= 1'b0;
      chase_q      <= 1'b0;
      scatter_q    <= 1'b1;
      reverse_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      phase_cnt_q  <= phase_cnt_d;
      fright_cnt_q <= fright_cnt_d;
      fright_q     <= fright_d;
      flash_q      <= flash_d;
      chase_q      <= chase_d;
      scatter_q    <= scatter_d;
      reverse_q    <= reverse_d;
    end
  end

  assign isChase      = chase_q;
  assign isScatter    = scatter_q;
  assign isFrightened = fright_q;
  assign fright_flash = flash_q;
  assign reverse      = reverse_q;
  assign phase        = phase_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// tb/tb_ghost_mode_ctrl.sv - scoreboard bench for ghost_mode_ctrl with a frame-count reference model
module tb_ghost_mode_ctrl;

  localparam int FR    = 5;
  localparam int FLASH = 2;
  localparam int DUR [7] = '{3, 4, 2, 2, 2, 2, 2};

  typedef struct {
    int phase;
    int cnt;
    int fr;
  } mstate_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic restart = 1'b0;
  logic energizer_eaten = 1'b0;

  logic       chase_a, scatter_a, fright_a, flash_a, rev_a;
  logic [2:0] phase_a;
  logic       chase_b, scatter_b, fright_b, flash_b, rev_b;
  logic [2:0] phase_b;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  mstate_t ma, mb;

  always #5 clk = ~clk;

  ghost_mode_ctrl #(
    .SCATTER1(3), .CHASE1(4), .SCATTER2(2), .CHASE2(2), .SCATTER3(2), .CHASE3(2),
    .SCATTER4(2), .FRIGHT_FRAMES(FR), .FLASH_FRAMES(FLASH), .CNT_W(11)
  ) u_dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .energizer_eaten(energizer_eaten), .isChase(chase_a), .isScatter(scatter_a),
    .isFrightened(fright_a), .fright_flash(flash_a), .reverse(rev_a), .phase(phase_a)
  );

  ghost_mode_ctrl #(
    .SCATTER1(3), .CHASE1(4), .SCATTER2(2), .CHASE2(2), .SCATTER3(2), .CHASE3(2),
    .SCATTER4(2), .FRIGHT_FRAMES(0), .FLASH_FRAMES(FLASH), .CNT_W(11)
  ) u_nofright (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .energizer_eaten(energizer_eaten), .isChase(chase_b), .isScatter(scatter_b),
    .isFrightened(fright_b), .fright_flash(flash_b), .reverse(rev_b), .phase(phase_b)
  );

  // Reference: frames elapsed in the current phase, frames of fright remaining.
  function automatic mstate_t model_next(input mstate_t s, input bit ft, input bit rs,
                                         input bit en, input int ff, output bit rev);
    mstate_t n = s;
    rev = 1'b0;
    if (rs) begin
      n.phase = 0; n.cnt = 0; n.fr = 0;
    end else if (en && ff != 0) begin
      n.fr = ff; rev = 1'b1;
    end else if (s.fr > 0) begin
      if (ft) n.fr = s.fr - 1;
    end else if (ft && s.phase < 7) begin
      n.cnt = s.cnt + 1;
      if (n.cnt == DUR[s.phase]) begin
        n.phase = s.phase + 1; n.cnt = 0; rev = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] expect_of(input mstate_t s, input bit rev);
    logic [2:0] p;
    bit frightened, odd;
    p = s.phase[2:0];
    frightened = (s.fr > 0);
    odd = (s.phase % 2) == 1;
    return {p, !frightened && odd, !frightened && !odd, frightened,
            frightened && s.fr <= FLASH, rev};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {phase,chase,scatter,fright,flash,rev}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic reset_model();
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};
  endtask

  task automatic step(input bit ft, input bit rs, input bit en);
    exp_t e;
    bit ra, rb;
    @(negedge clk);
    frame_tick = ft; restart = rs; energizer_eaten = en;
    ma = model_next(ma, ft, rs, en, FR, ra);
    mb = model_next(mb, ft, rs, en, 0, rb);
    e.a = expect_of(ma, ra);
    e.b = expect_of(mb, rb);
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("dut", {phase_a, chase_a, scatter_a, fright_a, flash_a, rev_a}, e.a);
        check("dut_nofright", {phase_b, chase_b, scatter_b, fright_b, flash_b, rev_b}, e.b);
      end
    end
  end

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    check("reset_a", {phase_a, chase_a, scatter_a, fright_a, flash_a, rev_a}, 8'b000_01000);
    check("reset_b", {phase_b, chase_b, scatter_b, fright_b, flash_b, rev_b}, 8'b000_01000);
    reset = 1'b1;

    ticks(67);                                     // schedule walk into phase 7 and hold
    step(0, 1, 0); ticks(5);                       // phase 1, phase_cnt 2
    step(0, 0, 1); ticks(10);                      // fright overlay, resume, advance
    step(0, 0, 1); ticks(4); step(0, 0, 1); ticks(6);   // re-energize
    step(0, 1, 0); ticks(2); step(1, 0, 1); ticks(7);   // energizer on phase-ending tick
    step(0, 1, 0); ticks(9); step(0, 0, 1); ticks(1); step(0, 1, 0);
    ticks(9); step(0, 0, 1); ticks(1); step(1, 1, 1);   // restart with coincident inputs
    step(0, 0, 0); step(1, 0, 1); ticks(4); step(1, 0, 1); step(0, 0, 1);  // expiry+reload
    step(0, 1, 0); ticks(14);                      // into phase 5

    @(negedge clk);
    frame_tick = 0; restart = 0; energizer_eaten = 0;
    #2 reset = 1'b0;
    #1;
    check("async_a", {phase_a, chase_a, scatter_a, fright_a, flash_a, rev_a}, 8'b000_01000);
    check("async_b", {phase_b, chase_b, scatter_b, fright_b, flash_b, rev_b}, 8'b000_01000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    reset_model();
    ticks(5);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0, $urandom_range(0, 99) < 4);

    @(negedge clk);
    frame_tick = 0; restart = 0; energizer_eaten = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
